alu_pipe: RTL

Parametrised, pipelined successor to the team's 8-bit combinational ALU. It adds a configurable datapath width, a valid/ready handshake on both sides, and a two-stage pipeline with full throughput. It also provides status flags and a persistent carry register, so wide additions and subtractions can be chained across transactions. It sits between an operand sequencer (upstream) and a result consumer (downstream) that may apply backpressure.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_ADC = 3'b110;
  localparam logic [2:0] OP_SBB = 3'b111;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Stateless ALU datapath: computes result and flags from operands and the current carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             carry_we
);

  logic [WIDTH:0] sum;
  logic           ci;
  logic           ovf;

  // Only ADC/SBB consume the carry register; ADD/SUB start from zero.
  assign ci = ((op == OP_ADC) || (op == OP_SBB)) ? cin : 1'b0;

  always_comb begin
    sum      = '0;
    result   = '0;
    ovf      = 1'b0;
    carry_we = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        result   = sum[WIDTH-1:0];
        carry_we = 1'b1;
        ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        // The extra top bit goes high exactly when a < b + ci, i.e. a borrow.
        sum      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
        result   = sum[WIDTH-1:0];
        carry_we = 1'b1;
        ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = ~a;
    endcase
  end

  always_comb begin
    flags   = '0;
    flags.z = (result == '0);
    flags.n = result[WIDTH-1];
    flags.c = carry_we ? sum[WIDTH] : cin;
    flags.v = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a persistent carry register for chained arithmetic.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       alu_op,
  input  logic             carry_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [2:0]       s1_op_reg;
  logic             carry_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  alu_flags_t       flags_reg;

  logic             s2_advance;
  logic             accept;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic             core_carry_we;

  assign s2_advance = !out_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_advance;
  assign accept     = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (s1_a_reg),
    .b        (s1_b_reg),
    .op       (s1_op_reg),
    .cin      (carry_reg),
    .result   (core_result),
    .flags    (core_flags),
    .carry_we (core_carry_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= OP_ADD;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= op_a;
      s1_b_reg     <= op_b;
      s1_op_reg    <= alu_op;
    end else if (s2_advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else if (s2_advance) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= core_result;
        flags_reg  <= core_flags;
      end
    end
  end

  // An arithmetic op entering stage 2 overrides a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (s2_advance && s1_valid_reg && core_carry_we) begin
      carry_reg <= core_flags.c;
    end else if (carry_clr) begin
      carry_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag_z    = flags_reg.z;
  assign flag_n    = flags_reg.n;
  assign flag_c    = flags_reg.c;
  assign flag_v    = flags_reg.v;

endmodule
